// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcode, state and control-select encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [6:0] {
    lw_op  = 7'b0000011,
    sw_op  = 7'b0100011,
    r_op   = 7'b0110011,
    i_op   = 7'b0010011,
    jal_op = 7'b1101111,
    beq_op = 7'b1100011,
    lui_op = 7'b0110111
  } opcodetype;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH, LUI, TRAP
  } statetype;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_BSETI = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  // Immediate format depends only on the opcode; R-type and unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      sw_op:   return IMM_S;
      beq_op:  return IMM_B;
      jal_op:  return IMM_J;
      lui_op:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - funct3/funct7 decode to ALU operation for R- and I-type instructions
module mc_aludec
  import mc_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      // funct7b5 only selects sub for R-type; in I-type it is an immediate bit
      3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_BSETI;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM with memory-stall watchdog and retired counter
module mc_controller
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             AdrSrc,
  output logic [2:0]       ALUControl,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemReq,
  output logic             Fault,
  output logic [CNT_W-1:0] retired
);

  statetype   state, next_state;
  logic [7:0] wait_cnt;
  logic [2:0] funct_alu;
  logic       funct_illegal;
  logic       taken;
  logic       stall_limit;

  mc_aludec u_aludec (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (funct_alu),
    .illegal     (funct_illegal)
  );

  // Only beq (000) and bne (001) ever reach BRANCH, so bit 0 picks the polarity.
  assign taken       = funct3[0] ? ~Zero : Zero;
  assign stall_limit = MemReq && !mem_ready && (wait_cnt == 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      if (MemReq && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                      wait_cnt <= '0;
      if (next_state == FETCH && state != FETCH)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          lw_op, sw_op: next_state = MEMADR;
          r_op:         next_state = funct_illegal ? TRAP : EXECR;
          i_op:         next_state = funct_illegal ? TRAP : EXECI;
          jal_op:       next_state = JAL;
          beq_op:       next_state = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
          lui_op:       next_state = LUI;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = (op == lw_op) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) next_state = MEMWB;
      MEMWRITE: if (mem_ready) next_state = FETCH;
      EXECR, EXECI, JAL:          next_state = ALUWB;
      MEMWB, ALUWB, BRANCH, LUI:  next_state = FETCH;
      TRAP:     next_state = TRAP;
      default:  next_state = TRAP;
    endcase
    if (stall_limit) next_state = TRAP;
  end

  always_comb begin
    ImmSrc     = imm_src_of(op);
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    ALUControl = ALU_ADD;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemReq     = 1'b0;
    Fault      = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        // Reset held low presents FETCH but must not commit the fetch.
        IRWrite   = mem_ready && reset;
        PCWrite   = mem_ready && reset;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        ALUControl = funct_alu;
      end
      EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct_alu;
      end
      ALUWB:    RegWrite = 1'b1;
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
      end
      LUI: begin
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
      end
      TRAP:     Fault = 1'b1;
      default:  Fault = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench: per-instruction phase model predicts every cycle's control word
module tb_mc_controller;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JALO = 7'b1101111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUIO = 7'b0110111;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BRANCH, P_LUI, P_TRAP} phase_e;

  typedef struct packed {
    logic [2:0] imm;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic [2:0] alu;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       mreq;
    logic       fault;
    logic [3:0] ret;
  } cw_t;

  typedef struct {
    string name;
    cw_t   cw;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             Zero;
  logic             mem_ready;
  logic [2:0]       ImmSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic             AdrSrc;
  logic [2:0]       ALUControl;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemReq;
  logic             Fault;
  logic [CNT_W-1:0] retired;

  cw_t  act_cw;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ret_m    = 0;

  mc_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .AdrSrc     (AdrSrc),
    .ALUControl (ALUControl),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemReq     (MemReq),
    .Fault      (Fault),
    .retired    (retired)
  );

  assign act_cw = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                   IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Fault, retired};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_of();
    if (op == SW)   return 3'b001;
    if (op == BR)   return 3'b010;
    if (op == JALO) return 3'b011;
    if (op == LUIO) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] alu_of();
    case (funct3)
      3'd0:    return (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'd1:    return 3'b111;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal_funct(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
  endfunction

  function automatic cw_t exp_cw(input phase_e p, input logic r);
    cw_t c;
    c     = '0;
    c.imm = imm_of();
    c.ret = 4'(ret_m);
    case (p)
      P_RESET:    begin c.mreq = 1; c.srcb = 2'b10; c.res = 2'b10; c.ret = 4'd0; end
      P_FETCH:    begin c.mreq = 1; c.srcb = 2'b10; c.res = 2'b10; c.irw = r; c.pcw = r; end
      P_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      P_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      P_MEMREAD:  begin c.mreq = 1; c.adr = 1; end
      P_MEMWB:    begin c.res = 2'b01; c.rw = 1; end
      P_MEMWRITE: begin c.mreq = 1; c.mw = 1; c.adr = 1; end
      P_EXECR:    begin c.srca = 2'b10; c.alu = alu_of(); end
      P_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.alu = alu_of(); end
      P_ALUWB:    c.rw = 1;
      P_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1; end
      P_BRANCH:   begin c.srca = 2'b10; c.alu = 3'b001; c.pcw = (funct3 == 3'd0) ? Zero : ~Zero; end
      P_LUI:      begin c.res = 2'b11; c.rw = 1; end
      P_TRAP:     c.fault = 1;
      default:    c.fault = 1;
    endcase
    return c;
  endfunction

  // One clock cycle in phase p: drive mem_ready, predict outputs, advance past the edge.
  task automatic step(input phase_e p, input logic r);
    exp_t e;
    mem_ready = r;
    e.name = p.name();
    e.cw   = exp_cw(p, r);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    ret_m = 0;
    repeat (n) step(P_RESET, 1'b1);
    reset = 1'b1;
  endtask

  // A memory phase stalls for 'stall' cycles; the (MAX_WAIT+1)-th stalled cycle is fatal.
  task automatic mem_phase(input phase_e p, input int stall, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step(p, 1'b0);
      if (i == MAX_WAIT) begin
        trapped = 1'b1;
        return;
      end
    end
    step(p, 1'b1);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int sf, input int sm);
    bit tr;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    mem_phase(P_FETCH, sf, tr);
    if (!tr) begin
      step(P_DECODE, rbit());
      case (o)
        LW: begin
          step(P_MEMADR, rbit());
          mem_phase(P_MEMREAD, sm, tr);
          if (!tr) step(P_MEMWB, rbit());
        end
        SW: begin
          step(P_MEMADR, rbit());
          mem_phase(P_MEMWRITE, sm, tr);
        end
        RT, IT: begin
          if (legal_funct(f3)) begin
            step((o == RT) ? P_EXECR : P_EXECI, rbit());
            step(P_ALUWB, rbit());
          end else tr = 1'b1;
        end
        JALO: begin
          step(P_JAL, rbit());
          step(P_ALUWB, rbit());
        end
        BR:      if (f3 == 3'd0 || f3 == 3'd1) step(P_BRANCH, rbit()); else tr = 1'b1;
        LUIO:    step(P_LUI, rbit());
        default: tr = 1'b1;
      endcase
    end
    if (tr) begin
      repeat (3) step(P_TRAP, rbit());
      do_reset(2);
    end else begin
      ret_m = (ret_m + 1) % (1 << CNT_W);
    end
  endtask

  function automatic int pick_stall();
    int r;
    r = $urandom_range(0, 39);
    if (r < 28) return 0;
    if (r < 39) return $urandom_range(1, MAX_WAIT);
    return MAX_WAIT + 1;
  endfunction

  task automatic random_instr();
    logic [6:0] o;
    logic [2:0] f3;
    logic [2:0] legal[5];
    int sel;
    legal = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    sel = $urandom_range(0, 15);
    f3  = legal[$urandom_range(0, 4)];
    case (sel)
      0, 1:    o = LW;
      2, 3:    o = SW;
      4, 5, 6: o = RT;
      7, 8, 9: o = IT;
      10:      o = JALO;
      11, 12:  begin o = BR; f3 = {2'b00, rbit()}; end
      13:      o = LUIO;
      14:      begin o = BR; f3 = 3'($urandom_range(0, 7)); end
      default: begin o = 7'($urandom_range(0, 127)); f3 = 3'($urandom_range(0, 7)); end
    endcase
    run_instr(o, f3, rbit(), rbit(), pick_stall(), pick_stall());
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_cw !== e.cw) begin
          failures++;
          $display("FAIL %s @%0t: actual=%06h required=%06h", e.name, $time, act_cw, e.cw);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0);   // add
    checks++;
    if (retired !== 4'(ret_m)) begin
      failures++;
      $display("FAIL add retired: actual=%0d required=%0d", retired, ret_m);
    end
    checks++;
    if (MemReq !== 1'b1 || Fault !== 1'b0) begin
      failures++;
      $display("FAIL add return to FETCH: MemReq=%b Fault=%b", MemReq, Fault);
    end
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL RegWrite asserted in FETCH");
    end
    run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0);   // sub
    run_instr(IT, 3'd0, 1'b1, 1'b0, 0, 0);   // addi keeps add despite bit 30
    run_instr(RT, 3'd2, 1'b0, 1'b0, 0, 0);   // slt
    run_instr(IT, 3'd6, 1'b0, 1'b0, 1, 0);   // ori
    run_instr(RT, 3'd7, 1'b0, 1'b0, 0, 0);   // and
    run_instr(IT, 3'd1, 1'b0, 1'b0, 0, 0);   // bseti
    run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 3);   // lw, 3 stalled MEMREAD cycles
    checks++;
    if (retired !== 4'(ret_m) || Fault !== 1'b0) begin
      failures++;
      $display("FAIL lw stall: retired=%0d required=%0d Fault=%b", retired, ret_m, Fault);
    end
    run_instr(SW, 3'd2, 1'b0, 1'b0, 1, 2);
    run_instr(BR, 3'd1, 1'b0, 1'b0, 0, 0);   // bne taken
    run_instr(BR, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    run_instr(BR, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    run_instr(BR, 3'd0, 1'b0, 1'b0, 0, 0);   // beq not taken
    run_instr(JALO, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(LUIO, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(RT, 3'd0, 1'b0, 1'b0, MAX_WAIT, 0);        // longest survivable fetch stall
    run_instr(LW, 3'd2, 1'b0, 1'b0, 0, MAX_WAIT);
    run_instr(RT, 3'd0, 1'b0, 1'b0, MAX_WAIT + 1, 0);    // fetch stall trap
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);       // unknown opcode
    run_instr(RT, 3'd5, 1'b0, 1'b0, 0, 0);               // unsupported funct3
    run_instr(BR, 3'd4, 1'b0, 1'b0, 0, 0);               // unsupported branch
    run_instr(SW, 3'd2, 1'b0, 1'b0, 0, MAX_WAIT + 1);    // write stall trap

    // reset in the middle of a stalled load and of a stalled fetch
    op = LW; funct3 = 3'd2;
    step(P_FETCH, 1'b1);
    step(P_DECODE, rbit());
    step(P_MEMADR, rbit());
    step(P_MEMREAD, 1'b0);
    step(P_MEMREAD, 1'b0);
    do_reset(2);
    step(P_FETCH, 1'b0);
    step(P_FETCH, 1'b0);
    do_reset(1);

    // retired counter wraps after 2^CNT_W instructions
    do_reset(1);
    repeat (16) run_instr(IT, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (retired !== 4'(ret_m)) begin
      failures++;
      $display("FAIL retired wrap: actual=%0d required=%0d", retired, ret_m);
    end

    for (int n = 0; n < 300; n++) random_instr();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: memory-stall cycles tolerated before fault; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- AdrSrc  out  1  0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 bseti
- IRWrite, PCWrite, RegWrite, MemWrite, MemReq  out  1 each  strobes
- Fault  out  1  sticky trap indicator
- retired  out  CNT_W  count of completed instructions

Function
REQ-004 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, LUI, TRAP.
REQ-005 SHALL assert only the following per state; all other strobes 0, all other selects 00, and ALUControl add unless stated:
- FETCH: MemReq, ALUSrcB=10, ResultSrc=10; IRWrite=PCWrite=mem_ready
- DECODE: ALUSrcA=01, ALUSrcB=01
- MEMADR: ALUSrcA=10, ALUSrcB=01
- MEMREAD: MemReq, AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite
- MEMWRITE: MemReq, MemWrite, AdrSrc=1
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct decode
- ALUWB: RegWrite
- JAL: ALUSrcA=01, ALUSrcB=10, PCWrite
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub; PCWrite=taken
- LUI: ResultSrc=11, RegWrite
- TRAP: Fault=1, all strobes 0
REQ-006 Transitions: FETCH->DECODE only when mem_ready=1, otherwise hold. DECODE->MEMADR (0000011, 0100011), EXECR (0110011), EXECI (0010011), JAL (1101111), BRANCH (1100011 with funct3 000 or 001), LUI (0110111); any other op or funct3 ->TRAP.
REQ-007 Transitions: MEMADR->MEMREAD for load, else MEMWRITE. MEMREAD->MEMWB on mem_ready. MEMWRITE->FETCH on mem_ready. EXECR, EXECI, JAL->ALUWB. MEMWB, ALUWB, BRANCH, LUI->FETCH. TRAP->TRAP.
REQ-008 Branch taken SHALL be Zero for funct3 000 (beq) and ~Zero for funct3 001 (bne).
REQ-009 Funct decode: funct3 000 gives sub when op[5]&funct7b5, else add; 001 gives bseti; 010 gives slt; 110 gives or; 111 gives and; any other funct3 in DECODE for R/I-type ->TRAP.
REQ-010 ImmSrc SHALL be decoded combinationally from op in every state; unknown op gives 000.
REQ-011 Wait counter SHALL increment each cycle MemReq=1 and mem_ready=0, and clear to 0 on any cycle with mem_ready=1 or MemReq=0; if it equals MAX_WAIT while mem_ready=0, next state SHALL be TRAP.
REQ-012 retired SHALL increment by 1 on every transition into FETCH from a non-FETCH state and wrap modulo 2^CNT_W.
REQ-013 mem_ready while MemReq=0 SHALL be ignored.

Reset
REQ-014 On reset low: state FETCH, wait counter 0, retired 0, Fault 0; all outputs take FETCH values (MemReq=1, IRWrite=PCWrite=0 until reset high).
REQ-015 Reset asserted mid-instruction, including in TRAP or mid-stall, SHALL abort immediately with no further strobes.

Structure
REQ-016 Package mc_pkg SHALL hold opcodetype (adds lui_op=0110111), statetype, and the ImmSrc/ALUControl/mux-select encodings.
REQ-017 The funct decode SHALL be sub-module mc_aludec; the FSM, wait counter and retired counter live in mc_controller.

Verification
REQ-018 add (0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB, 4 cycles; ALUControl=000; retired 0->1.
REQ-019 lw, with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite in MEMWB only, no TRAP.
REQ-020 bne with Zero=0 -> PCWrite=1 in BRANCH; with Zero=1 -> PCWrite=0; both return to FETCH.
REQ-021 mem_ready held 0 in FETCH, MAX_WAIT=4 -> TRAP after the 5th stalled cycle, Fault=1 sticky, no strobes; reset low clears it.
REQ-022 op=1111111 -> TRAP from DECODE; lui -> RegWrite with ResultSrc=11, ImmSrc=100.
REQ-023 CNT_W=4, 16 addi instructions -> retired wraps to 0.
